// File: rtl/pic_pkg.sv
// Shared definitions for the INTA# initiator: FSM encoding, the MCS-80 CALL opcode
// and the number of INTA# pulses for each CPU protocol.
package pic_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PULSE_LOW  = 2'd1,
    PULSE_HIGH = 2'd2,
    PRESENT    = 2'd3
  } state_t;

  localparam logic [7:0] CALL_OPCODE  = 8'hCD;
  localparam logic [1:0] PULSES_8086  = 2'd2;
  localparam logic [1:0] PULSES_MCS80 = 2'd3;

  // Index of the last pulse; the pulse counter holds the number of completed pulses.
  function automatic logic [1:0] final_pulse_index(input logic is_8086);
    return is_8086 ? (PULSES_8086 - 2'd1) : (PULSES_MCS80 - 2'd1);
  endfunction

endpackage

// File: rtl/inta_pulse_timer.sv
// Phase timer for the INTA# pulse train: counts cycles spent in the low or high
// phase and flags the cycle on which the current phase ends.
module inta_pulse_timer
  import pic_pkg::*;
#(
  parameter int unsigned INTA_LOW_CYCLES  = 2,
  parameter int unsigned INTA_HIGH_CYCLES = 2
) (
  input  logic   clock,
  input  logic   reset,
  input  state_t state,
  output logic   phase_done
);

  localparam logic [3:0] LOW_LIMIT  = 4'(INTA_LOW_CYCLES - 1);
  localparam logic [3:0] HIGH_LIMIT = 4'(INTA_HIGH_CYCLES - 1);

  logic [3:0] phase_cnt;
  logic [3:0] limit;
  logic       active;

  assign active     = (state == PULSE_LOW) || (state == PULSE_HIGH);
  assign limit      = (state == PULSE_LOW) ? LOW_LIMIT : HIGH_LIMIT;
  assign phase_done = active && (phase_cnt == limit);

  // Counter restarts at every phase boundary so each phase is timed from zero.
  always_ff @(posedge clock) begin
    if (reset || !active || phase_done) begin
      phase_cnt <= 4'd0;
    end else begin
      phase_cnt <= phase_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/interrupt_acknowledge_initiator.sv
// CPU-side INTA# sequencer for an 8259A: issues the acknowledge pulse train, captures
// the returned bytes and hands the vector to the core. Optional macro: INTA_OPCODE_CHECK_EN.
module interrupt_acknowledge_initiator
  import pic_pkg::*;
#(
  parameter int unsigned INTA_LOW_CYCLES  = 2,
  parameter int unsigned INTA_HIGH_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        interrupt_to_cpu,
  input  logic        interrupt_enable,
  input  logic        mode_8086,
  input  logic [7:0]  data_bus_in,
  input  logic        vector_accept,
  output logic        interrupt_acknowledge_n,
  output logic        acknowledge_busy,
  output logic        vector_valid,
  output logic [7:0]  vector_type,
  output logic [15:0] call_address,
  output logic        call_opcode_error
);

  state_t      state;
  state_t      state_next;
  logic        phase_done;
  logic        mode_latched;
  logic [1:0]  pulse_cnt;
  logic        start;
  logic        capture;
  logic        last_pulse;

  inta_pulse_timer #(
    .INTA_LOW_CYCLES (INTA_LOW_CYCLES),
    .INTA_HIGH_CYCLES(INTA_HIGH_CYCLES)
  ) u_timer (
    .clock     (clock),
    .reset     (reset),
    .state     (state),
    .phase_done(phase_done)
  );

  assign start      = (state == IDLE) && interrupt_to_cpu && interrupt_enable;
  assign capture    = (state == PULSE_LOW) && phase_done;
  assign last_pulse = (pulse_cnt == final_pulse_index(mode_latched));

  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (start) state_next = PULSE_LOW;
      PULSE_LOW:  if (phase_done) state_next = last_pulse ? PRESENT : PULSE_HIGH;
      PULSE_HIGH: if (phase_done) state_next = PULSE_LOW;
      PRESENT:    if (vector_accept) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // INTA# is registered from the next state so it is low exactly while in PULSE_LOW.
  always_ff @(posedge clock) begin
    if (reset) begin
      state                   <= IDLE;
      interrupt_acknowledge_n <= 1'b1;
      mode_latched            <= 1'b0;
      pulse_cnt               <= 2'd0;
      vector_type             <= 8'h00;
      call_address            <= 16'h0000;
    end else begin
      state                   <= state_next;
      interrupt_acknowledge_n <= (state_next != PULSE_LOW);
      if (start) begin
        mode_latched <= mode_8086;
        pulse_cnt    <= 2'd0;
      end
      if (capture) begin
        pulse_cnt <= pulse_cnt + 2'd1;
        if (mode_latched) begin
          if (pulse_cnt == 2'd1) vector_type <= data_bus_in;
        end else begin
          case (pulse_cnt)
            2'd1:    call_address[7:0]  <= data_bus_in;
            2'd2:    call_address[15:8] <= data_bus_in;
            default: ;
          endcase
        end
      end
    end
  end

  assign acknowledge_busy = (state != IDLE);
  assign vector_valid     = (state == PRESENT);

`ifdef INTA_OPCODE_CHECK_EN
  logic opcode_err_q;

  // Only the MCS-80 first byte is checked; the flag is visible only while presenting.
  always_ff @(posedge clock) begin
    if (reset || start || ((state == PRESENT) && vector_accept)) begin
      opcode_err_q <= 1'b0;
    end else if (capture && !mode_latched && (pulse_cnt == 2'd0)) begin
      opcode_err_q <= (data_bus_in != CALL_OPCODE);
    end
  end

  assign call_opcode_error = opcode_err_q && (state == PRESENT);
`else
  assign call_opcode_error = 1'b0;
`endif

endmodule

// File: tb/tb_interrupt_acknowledge_initiator.sv
// Directed self-checking bench for interrupt_acknowledge_initiator at default timing.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_interrupt_acknowledge_initiator;

  localparam int INTA_LOW  = 2;
  localparam int INTA_HIGH = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        interrupt_to_cpu;
  logic        interrupt_enable;
  logic        mode_8086;
  logic [7:0]  data_bus_in;
  logic        vector_accept;
  logic        interrupt_acknowledge_n;
  logic        acknowledge_busy;
  logic        vector_valid;
  logic [7:0]  vector_type;
  logic [15:0] call_address;
  logic        call_opcode_error;

  int errors = 0;
  int checks = 0;

  interrupt_acknowledge_initiator #(
    .INTA_LOW_CYCLES (INTA_LOW),
    .INTA_HIGH_CYCLES(INTA_HIGH)
  ) dut (
    .clock                  (clock),
    .reset                  (reset),
    .interrupt_to_cpu       (interrupt_to_cpu),
    .interrupt_enable       (interrupt_enable),
    .mode_8086              (mode_8086),
    .data_bus_in            (data_bus_in),
    .vector_accept          (vector_accept),
    .interrupt_acknowledge_n(interrupt_acknowledge_n),
    .acknowledge_busy       (acknowledge_busy),
    .vector_valid           (vector_valid),
    .vector_type            (vector_type),
    .call_address           (call_address),
    .call_opcode_error      (call_opcode_error)
  );

  always #5 clock = ~clock;

  // Starts a sequence on the next rising edge and plays the PIC: a new byte is put on
  // the bus for every INTA# low window. Returns once vector_valid is seen (or budget out).
  task automatic run_seq(input logic m8086, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic drop_int, input logic flip_mode,
                         output int lows, output int latency, output int bad_len);
    logic [7:0] bytes [3];
    int low_len;
    logic prev;
    bytes[0] = b0; bytes[1] = b1; bytes[2] = b2;
    lows = 0; latency = -1; bad_len = 0; low_len = 0; prev = 1'b1;
    mode_8086 = m8086;
    interrupt_to_cpu = 1'b1;
    interrupt_enable = 1'b1;
    for (int c = 0; c < 40 && latency < 0; c++) begin
      @(negedge clock);
      if (interrupt_acknowledge_n == 1'b0) begin
        if (prev == 1'b1) begin
          lows++;
          low_len = 0;
          if (lows <= 3) data_bus_in = bytes[lows-1];
        end
        low_len++;
      end else if (prev == 1'b0) begin
        if (low_len != INTA_LOW) bad_len++;
        if (drop_int) interrupt_to_cpu = 1'b0;
        if (flip_mode) mode_8086 = ~m8086;
      end
      prev = interrupt_acknowledge_n;
      if (vector_valid === 1'b1) latency = c;
    end
  endtask

  task automatic do_accept();
    vector_accept = 1'b1;
    interrupt_to_cpu = 1'b0;
    @(negedge clock);
    vector_accept = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    interrupt_to_cpu = 1'b0;
    interrupt_enable = 1'b0;
    mode_8086 = 1'b1;
    data_bus_in = 8'h00;
    vector_accept = 1'b0;
    repeat (2) @(negedge clock);
    checks++; if (interrupt_acknowledge_n !== 1'b1) begin errors++; $display("[TB] FAIL reset_inta: got %b expected 1", interrupt_acknowledge_n); end
    checks++; if (acknowledge_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", acknowledge_busy); end
    checks++; if (vector_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", vector_valid); end
    checks++; if (vector_type !== 8'h00) begin errors++; $display("[TB] FAIL reset_type: got %h expected 00", vector_type); end
    checks++; if (call_address !== 16'h0000) begin errors++; $display("[TB] FAIL reset_addr: got %h expected 0000", call_address); end
    checks++; if (call_opcode_error !== 1'b0) begin errors++; $display("[TB] FAIL reset_operr: got %b expected 0", call_opcode_error); end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_8086();
    int lows, lat, bad;
    run_seq(1'b1, 8'hFF, 8'h4A, 8'h00, 1'b0, 1'b0, lows, lat, bad);
    checks++; if (lows != 2) begin errors++; $display("[TB] FAIL 8086_lows: got %0d expected 2", lows); end
    checks++; if (lat != 6) begin errors++; $display("[TB] FAIL 8086_latency: got %0d expected 6", lat); end
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL 8086_low_width: got %0d bad windows expected 0", bad); end
    checks++; if (vector_type !== 8'h4A) begin errors++; $display("[TB] FAIL 8086_type: got %h expected 4a", vector_type); end
    checks++; if (acknowledge_busy !== 1'b1) begin errors++; $display("[TB] FAIL 8086_busy: got %b expected 1", acknowledge_busy); end
    checks++; if (call_opcode_error !== 1'b0) begin errors++; $display("[TB] FAIL 8086_operr: got %b expected 0", call_opcode_error); end
    do_accept();
    checks++; if (vector_valid !== 1'b0) begin errors++; $display("[TB] FAIL 8086_accept_valid: got %b expected 0", vector_valid); end
    checks++; if (acknowledge_busy !== 1'b0) begin errors++; $display("[TB] FAIL 8086_accept_busy: got %b expected 0", acknowledge_busy); end
  endtask

  task automatic test_mcs80(input logic [7:0] op, input logic [7:0] lo, input logic [7:0] hi,
                            input logic flip, input logic exp_err);
    int lows, lat, bad;
    run_seq(1'b0, op, lo, hi, 1'b0, flip, lows, lat, bad);
    checks++; if (lows != 3) begin errors++; $display("[TB] FAIL mcs80_lows: got %0d expected 3", lows); end
    checks++; if (lat != 10) begin errors++; $display("[TB] FAIL mcs80_latency: got %0d expected 10", lat); end
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL mcs80_low_width: got %0d bad windows expected 0", bad); end
    checks++; if (call_address !== {hi, lo}) begin errors++; $display("[TB] FAIL mcs80_addr: got %h expected %h", call_address, {hi, lo}); end
    checks++; if (call_opcode_error !== exp_err) begin errors++; $display("[TB] FAIL mcs80_operr: got %b expected %b", call_opcode_error, exp_err); end
    do_accept();
    checks++; if (vector_valid !== 1'b0) begin errors++; $display("[TB] FAIL mcs80_accept_valid: got %b expected 0", vector_valid); end
    checks++; if (call_opcode_error !== 1'b0) begin errors++; $display("[TB] FAIL mcs80_accept_operr: got %b expected 0", call_opcode_error); end
  endtask

  task automatic test_hold_present();
    int lows, lat, bad;
    int stable_bad = 0;
    run_seq(1'b1, 8'h00, 8'h99, 8'h00, 1'b0, 1'b0, lows, lat, bad);
    checks++; if (lat != 6) begin errors++; $display("[TB] FAIL hold_latency: got %0d expected 6", lat); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (vector_valid !== 1'b1 || interrupt_acknowledge_n !== 1'b1 || vector_type !== 8'h99)
        stable_bad++;
    end
    checks++; if (stable_bad != 0) begin errors++; $display("[TB] FAIL hold_stable: got %0d unstable cycles expected 0", stable_bad); end
    vector_accept = 1'b1;
    @(negedge clock);
    vector_accept = 1'b0;
    checks++; if (vector_valid !== 1'b0 || acknowledge_busy !== 1'b0 || interrupt_acknowledge_n !== 1'b1) begin
      errors++; $display("[TB] FAIL hold_accept: got valid=%b busy=%b inta=%b expected 0 0 1", vector_valid, acknowledge_busy, interrupt_acknowledge_n); end
    @(negedge clock);
    checks++; if (acknowledge_busy !== 1'b1 || interrupt_acknowledge_n !== 1'b0) begin
      errors++; $display("[TB] FAIL hold_restart: got busy=%b inta=%b expected 1 0", acknowledge_busy, interrupt_acknowledge_n); end
    interrupt_to_cpu = 1'b0;
    lat = -1;
    for (int c = 0; c < 30 && lat < 0; c++) begin
      @(negedge clock);
      if (vector_valid === 1'b1) lat = c;
    end
    checks++; if (lat < 0) begin errors++; $display("[TB] FAIL hold_drain: got no vector_valid expected one within 30 cycles"); end
    do_accept();
  endtask

  task automatic test_int_drop();
    int lows, lat, bad;
    run_seq(1'b1, 8'h00, 8'h5C, 8'h00, 1'b1, 1'b0, lows, lat, bad);
    checks++; if (lows != 2) begin errors++; $display("[TB] FAIL drop_lows: got %0d expected 2", lows); end
    checks++; if (vector_type !== 8'h5C) begin errors++; $display("[TB] FAIL drop_type: got %h expected 5c", vector_type); end
    do_accept();
  endtask

  task automatic test_enable_off();
    int toggles = 0;
    interrupt_to_cpu = 1'b1;
    interrupt_enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (interrupt_acknowledge_n !== 1'b1 || acknowledge_busy !== 1'b0) toggles++;
    end
    checks++; if (toggles != 0) begin errors++; $display("[TB] FAIL enable_off: got %0d active cycles expected 0", toggles); end
    interrupt_to_cpu = 1'b0;
    interrupt_enable = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_reset_mid();
    int lows = 0;
    int lat, bad;
    logic prev = 1'b1;
    mode_8086 = 1'b1;
    interrupt_to_cpu = 1'b1;
    interrupt_enable = 1'b1;
    for (int c = 0; c < 20 && lows < 2; c++) begin
      @(negedge clock);
      if (interrupt_acknowledge_n == 1'b0 && prev == 1'b1) lows++;
      prev = interrupt_acknowledge_n;
    end
    checks++; if (lows != 2) begin errors++; $display("[TB] FAIL rstmid_reach: got %0d windows expected 2", lows); end
    reset = 1'b1;
    @(negedge clock);
    checks++; if (interrupt_acknowledge_n !== 1'b1 || acknowledge_busy !== 1'b0 || vector_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL rstmid_state: got inta=%b busy=%b valid=%b expected 1 0 0", interrupt_acknowledge_n, acknowledge_busy, vector_valid); end
    reset = 1'b0;
    interrupt_to_cpu = 1'b0;
    @(negedge clock);
    run_seq(1'b1, 8'h33, 8'h77, 8'h00, 1'b0, 1'b0, lows, lat, bad);
    checks++; if (lat != 6) begin errors++; $display("[TB] FAIL rstmid_latency: got %0d expected 6", lat); end
    checks++; if (vector_type !== 8'h77) begin errors++; $display("[TB] FAIL rstmid_type: got %h expected 77", vector_type); end
    do_accept();
  endtask

  initial begin
    logic exp_err;
`ifdef INTA_OPCODE_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    test_reset();
    test_8086();
    test_mcs80(8'hCD, 8'h34, 8'h12, 1'b0, 1'b0);
    test_mcs80(8'hC3, 8'h78, 8'h56, 1'b0, exp_err);
    test_mcs80(8'hCD, 8'hBE, 8'hEF, 1'b1, 1'b0);
    test_hold_present();
    test_int_drop();
    test_enable_off();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/interrupt_acknowledge_initiator.md
Name: interrupt_acknowledge_initiator

Overview:
CPU-side counterpart of the 8259A control logic. It watches the PIC's interrupt_to_cpu line. When the CPU has interrupts enabled, it drives the INTA# pulse train: two pulses in 8086 mode, three in MCS-80 mode. It captures the bytes the PIC returns on the data bus and presents the resulting vector to the CPU core through a valid/accept handshake. It sits between the PIC data-bus/INTA pins and the core's interrupt entry logic.

Parameters:
INTA_LOW_CYCLES, 2, clock cycles INTA# is held low per pulse; legal range 1..15.
INTA_HIGH_CYCLES, 2, clock cycles INTA# is held high between pulses; legal range 1..15.

Ports:
clock  input  1  single system clock; all state changes on the rising edge.
reset  input  1  synchronous, active-high reset.
interrupt_to_cpu  input  1  INT from the 8259A; level-sensitive.
interrupt_enable  input  1  CPU interrupt-enable flag; a sequence starts only when this is 1.
mode_8086  input  1  1 = 8086/8088 two-pulse protocol; 0 = MCS-80 three-pulse protocol.
data_bus_in  input  8  byte driven by the PIC during INTA# low.
vector_accept  input  1  core consumes the vector when vector_valid=1 and vector_accept=1.
interrupt_acknowledge_n  output  1  INTA# to the PIC; registered, active-low.
acknowledge_busy  output  1  high from sequence start until the vector is accepted.
vector_valid  output  1  captured vector is available.
vector_type  output  8  8086 interrupt type byte (second pulse).
call_address  output  16  MCS-80 CALL target: {third byte, second byte}.
call_opcode_error  output  1  MCS-80 first byte was not 8'hCD (see Optional Feature).

Behaviour:
- Reset values: interrupt_acknowledge_n=1; acknowledge_busy=0; vector_valid=0; vector_type=8'h00; call_address=16'h0000; call_opcode_error=0; FSM=IDLE; pulse and phase counters=0.
- FSM states: IDLE, PULSE_LOW, PULSE_HIGH, PRESENT.
- IDLE -> PULSE_LOW:
  - Condition: interrupt_to_cpu=1 and interrupt_enable=1 on the same edge.
  - On that edge: INTA# goes 0, acknowledge_busy goes 1, mode_8086 is latched, and the pulse counter is cleared.
- PULSE_LOW:
  - INTA# stays low for exactly INTA_LOW_CYCLES cycles.
  - data_bus_in is sampled on the edge that returns INTA# to 1.
  - That same edge increments the pulse counter.
- Byte routing:
  - 8086 mode: pulse 1 byte is discarded; pulse 2 byte goes to vector_type.
  - MCS-80 mode: pulse 1 byte is the opcode; pulse 2 goes to call_address[7:0]; pulse 3 goes to call_address[15:8].
- After the final pulse (2 in 8086 mode, 3 in MCS-80 mode): next state is PRESENT, and vector_valid=1 on the same edge that raises INTA#.
- Otherwise: next state is PULSE_HIGH. INTA# stays high for exactly INTA_HIGH_CYCLES cycles, then returns to PULSE_LOW.
- PRESENT:
  - vector_valid, vector_type, call_address and call_opcode_error are held stable until vector_accept=1.
  - On the accepting edge: vector_valid=0, acknowledge_busy=0, next state IDLE.
  - A new sequence can start no earlier than the edge after acceptance.
- Latency, measured from the start edge to vector_valid:
  - 8086: 2*INTA_LOW_CYCLES + INTA_HIGH_CYCLES cycles (6 at defaults).
  - MCS-80: 3*INTA_LOW_CYCLES + 2*INTA_HIGH_CYCLES cycles (10 at defaults).
- Boundary conditions:
  - interrupt_to_cpu or interrupt_enable falling mid-sequence: ignored; the sequence always completes. Spurious handling belongs to the PIC.
  - mode_8086 changing mid-sequence: ignored; the latched value governs the whole sequence.
  - interrupt_to_cpu still high while in PRESENT: no new sequence until acceptance and return to IDLE.
  - reset asserted mid-sequence: next edge forces all reset values, including INTA# high, even mid-pulse.
  - vector_accept while not in PRESENT: ignored.
- Width rules:
  - Phase counter is 4 bits and compared against (parameter-1).
  - Pulse counter is 2 bits.

Optional Feature:
Macro INTA_OPCODE_CHECK_EN.
- Defined: in MCS-80 mode, the pulse-1 byte is compared with 8'hCD. call_opcode_error=1 on mismatch, valid alongside vector_valid and cleared on accept. In 8086 mode it is always 0.
- Not defined: the comparison logic is absent and call_opcode_error is tied to 0.

Decomposition:
- Shared package pic_pkg:
  - FSM state encoding (2-bit localparams IDLE, PULSE_LOW, PULSE_HIGH, PRESENT).
  - CALL_OPCODE = 8'hCD.
  - Pulse counts PULSES_8086 = 2 and PULSES_MCS80 = 3.
- One sub-module: inta_pulse_timer. It owns the phase counter and low/high timing, and emits phase_done to the FSM.

Test Plan:
- 8086 defaults: INT=1, enable=1; bus drives 8'hFF on pulse 1 and 8'h4A on pulse 2 -> exactly two INTA# low windows of 2 cycles; vector_valid 6 cycles after start; vector_type=8'h4A.
- MCS-80: bytes CD, 34, 12 -> three low windows; call_address=16'h1234; call_opcode_error=0; vector_valid 10 cycles after start.
- MCS-80 with INTA_OPCODE_CHECK_EN: first byte 8'hC3 -> call_opcode_error=1 with vector_valid; cleared after accept. Without the macro it stays 0.
- Hold vector_accept=0 for 20 cycles with INT still high -> vector_valid and data stable, INTA# stays 1, no second sequence; accept -> IDLE, then a new sequence starts the edge after.
- INT deasserted after pulse 1 -> pulse 2 still issued and vector presented; interrupt_enable=0 with INT=1 -> INTA# never toggles.
- Reset asserted during the second INTA# low window -> INTA#=1, busy=0, valid=0 on the next edge; a fresh sequence runs normally afterwards.
